// File: rtl/uop_pkg.sv
// Shared opcode map, field layout and the pure micro-op decode function
// used by the decode stage.
package uop_pkg;

    localparam int UOP_W = 32;

    localparam logic [5:0] OP_ALU_R  = 6'h01;
    localparam logic [5:0] OP_ALU_I  = 6'h02;
    localparam logic [5:0] OP_LOAD   = 6'h03;
    localparam logic [5:0] OP_STORE  = 6'h04;
    localparam logic [5:0] OP_LUI    = 6'h05;
    localparam logic [5:0] OP_BRANCH = 6'h06;
    localparam logic [5:0] OP_HALT   = 6'h3F;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RD_MSB  = 25;
    localparam int RD_LSB  = 21;
    localparam int RS1_MSB = 20;
    localparam int RS1_LSB = 16;
    localparam int RS2_MSB = 15;
    localparam int RS2_LSB = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        illegal;
    } decoded_uop_t;

    function automatic decoded_uop_t decode_uop(input logic [UOP_W-1:0] word);
        decoded_uop_t u;
        logic [31:0]  simm;
        simm      = {{16{word[IMM_MSB]}}, word[IMM_MSB:IMM_LSB]};
        u.opcode  = word[OPC_MSB:OPC_LSB];
        u.rd      = word[RD_MSB:RD_LSB];
        u.rs1     = word[RS1_MSB:RS1_LSB];
        u.rs2     = '0;
        u.imm     = '0;
        u.illegal = 1'b0;
        case (u.opcode)
            OP_ALU_R: u.rs2 = word[RS2_MSB:RS2_LSB];
            OP_ALU_I, OP_LOAD: u.imm = simm;
            OP_STORE: begin
                u.rs2 = word[RS2_MSB:RS2_LSB];
                u.imm = simm;
            end
            OP_LUI:    u.imm = {word[IMM_MSB:IMM_LSB], 16'h0000};
            OP_BRANCH: u.imm = {simm[29:0], 2'b00};
            OP_HALT:   u.imm = '0;
            // Unknown opcodes still flow downstream, decoded like a register op.
            default: begin
                u.rs2     = word[RS2_MSB:RS2_LSB];
                u.illegal = 1'b1;
            end
        endcase
        return u;
    endfunction

endpackage

// File: rtl/uop_decode_queue.sv
// Circular micro-op buffer: up to two pushes and one pop per cycle,
// power-of-two depth so the pointers wrap naturally.
module uop_queue
    import uop_pkg::*;
#(
    parameter int WIDTH = UOP_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_i,
    input  logic                     push1_i,
    input  logic [WIDTH-1:0]         data1_i,
    input  logic                     push2_i,
    input  logic [WIDTH-1:0]         data2_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    wrPtrNext;
    logic [WIDTH-1:0] firstData;
    logic             firstWe;
    logic             secondWe;
    logic [1:0]       numPush;

    // A lone younger word takes the first free slot so the queue stays dense.
    always_comb begin
        firstWe   = push1_i || push2_i;
        secondWe  = push1_i && push2_i;
        firstData = push1_i ? data1_i : data2_i;
        wrPtrNext = wrPtr_q + PW'(1);
        numPush   = {1'b0, push1_i} + {1'b0, push2_i};
        wrPtr_d   = wrPtr_q + PW'(numPush);
        rdPtr_d   = rdPtr_q + PW'(pop_i);
        count_d   = count_q + CW'(numPush) - CW'(pop_i);
        if (clear_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (firstWe) begin
            mem_q[wrPtr_q] <= firstData;
        end
        if (secondWe) begin
            mem_q[wrPtrNext] <= data2_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rdPtr_q];
    assign count_o = count_q;

endmodule

// File: rtl/uop_decode.sv
// Decode stage: buffers fetched micro-op pairs, drops NOPs and emits one
// decoded op per cycle to issue under a valid/stall handshake.
module uop_decode
    import uop_pkg::*;
#(
    parameter int UOP_WIDTH   = 32,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 prev_valid,
    input  logic [UOP_WIDTH-1:0] instruction_1,
    input  logic [UOP_WIDTH-1:0] instruction_2,
    output logic                 stalled,
    input  logic                 next_stalled,
    output logic                 valid,
    output logic [5:0]           opcode,
    output logic [4:0]           rd,
    output logic [4:0]           rs1,
    output logic [4:0]           rs2,
    output logic [31:0]          imm,
    output logic                 illegal
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    logic [CW-1:0]        count;
    logic [UOP_WIDTH-1:0] head;
    logic                 accept;
    logic                 push1;
    logic                 push2;
    logic                 pop;
    decoded_uop_t         outUop_q, outUop_d;
    logic                 outValid_q, outValid_d;

    // Registered count only, so fetch never sees a path from next_stalled.
    assign stalled = (CW'(QUEUE_DEPTH) - count) < CW'(2);

    uop_queue #(
        .WIDTH (UOP_WIDTH),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .clear_i (clear),
        .push1_i (push1),
        .data1_i (instruction_1),
        .push2_i (push2),
        .data2_i (instruction_2),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count)
    );

    always_comb begin
        accept     = prev_valid && !stalled && !clear;
        push1      = accept && (instruction_1 != '0);
        push2      = accept && (instruction_2 != '0);
        pop        = (count != '0) && (!outValid_q || !next_stalled) && !clear;
        outUop_d   = outUop_q;
        outValid_d = outValid_q;
        if (clear) begin
            outValid_d = 1'b0;
        end else if (pop) begin
            outUop_d   = decode_uop(head);
            outValid_d = 1'b1;
        end else if (!next_stalled) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outUop_q   <= '0;
            outValid_q <= 1'b0;
        end else begin
            outUop_q   <= outUop_d;
            outValid_q <= outValid_d;
        end
    end

    assign valid   = outValid_q;
    assign opcode  = outUop_q.opcode;
    assign rd      = outUop_q.rd;
    assign rs1     = outUop_q.rs1;
    assign rs2     = outUop_q.rs2;
    assign imm     = outUop_q.imm;
    assign illegal = outUop_q.illegal;

endmodule

// File: tb/tb_uop_decode.sv
// Scoreboard bench for uop_decode: expected ops are queued as pairs are
// accepted and compared as the issue side consumes them.
module tb_uop_decode;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        prev_valid;
    logic [31:0] instruction_1;
    logic [31:0] instruction_2;
    logic        stalled;
    logic        next_stalled;
    logic        valid;
    logic [5:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        illegal;
    logic [53:0] curOut;

    int          checkCount = 0;
    int          errorCount = 0;
    int          modelCount = 0;
    int          consumed   = 0;
    logic        modelValid = 1'b0;
    logic        holdPrev   = 1'b0;
    logic [53:0] holdRef    = '0;
    logic [53:0] sb[$];

    always #5 clk = ~clk;

    uop_decode #(
        .UOP_WIDTH   (32),
        .QUEUE_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .prev_valid    (prev_valid),
        .instruction_1 (instruction_1),
        .instruction_2 (instruction_2),
        .stalled       (stalled),
        .next_stalled  (next_stalled),
        .valid         (valid),
        .opcode        (opcode),
        .rd            (rd),
        .rs1           (rs1),
        .rs2           (rs2),
        .imm           (imm),
        .illegal       (illegal)
    );

    assign curOut = {opcode, rd, rs1, rs2, imm, illegal};

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference decode written straight from the opcode table.
    function automatic logic [53:0] expDecode(input logic [31:0] w);
        logic [5:0]  op;
        logic [4:0]  r2;
        logic [31:0] sx;
        logic [31:0] im;
        logic        ill;
        op  = w[31:26];
        sx  = {{16{w[15]}}, w[15:0]};
        r2  = 5'd0;
        im  = 32'd0;
        ill = 1'b0;
        case (op)
            6'h01: r2 = w[15:11];
            6'h02, 6'h03: im = sx;
            6'h04: begin r2 = w[15:11]; im = sx; end
            6'h05: im = {w[15:0], 16'h0};
            6'h06: im = sx << 2;
            6'h3F: im = 32'd0;
            default: begin r2 = w[15:11]; ill = 1'b1; end
        endcase
        return {op, w[25:21], w[20:16], r2, im, ill};
    endfunction

    function automatic logic [31:0] bpWord(input int idx, input int half);
        logic [5:0] op;
        case ((2 * idx + half) % 6)
            0: op = 6'h01;
            1: op = 6'h02;
            2: op = 6'h03;
            3: op = 6'h04;
            4: op = 6'h05;
            default: op = 6'h06;
        endcase
        return {op, 5'(idx), 5'(half + 1), 16'(idx * 4099 + half * 777)};
    endfunction

    task automatic applyStimulus(input logic pv, input logic [31:0] w1,
                                 input logic [31:0] w2, input logic ns,
                                 input logic clr);
        logic        modelStalled;
        logic        modelPop;
        int          pushes;
        logic [53:0] exp;
        prev_valid    = pv;
        instruction_1 = w1;
        instruction_2 = w2;
        next_stalled  = ns;
        clear         = clr;
        @(negedge clk);
        modelStalled = (DEPTH - modelCount) < 2;
        checkOutput("stalled", 64'(stalled), 64'(modelStalled));
        checkOutput("valid", 64'(valid), 64'(modelValid));
        if (holdPrev) checkOutput("hold", 64'(curOut), 64'(holdRef));
        pushes = 0;
        if (pv && !modelStalled && !clr) begin
            if (w1 != 32'h0) begin sb.push_back(expDecode(w1)); pushes++; end
            if (w2 != 32'h0) begin sb.push_back(expDecode(w2)); pushes++; end
        end
        if (valid && !ns && !clr) begin
            consumed++;
            if (sb.size() == 0) begin
                checkOutput("sbEmpty", 64'(1), 64'(0));
            end else begin
                exp = sb.pop_front();
                checkOutput("uop", 64'(curOut), 64'(exp));
            end
        end
        holdPrev = valid && ns && !clr;
        holdRef  = curOut;
        modelPop = (modelCount > 0) && (!modelValid || !ns) && !clr;
        @(posedge clk);
        if (clr) begin
            modelCount = 0;
            modelValid = 1'b0;
            sb.delete();
        end else begin
            modelCount = modelCount + pushes - (modelPop ? 1 : 0);
            if (modelPop) modelValid = 1'b1;
            else if (!ns) modelValid = 1'b0;
        end
        #1;
    endtask

    task automatic idle(input logic ns);
        applyStimulus(1'b0, 32'h0, 32'h0, ns, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int idx;
        int budget;
        int startConsumed;
        reset         = 1'b0;
        clear         = 1'b0;
        prev_valid    = 1'b0;
        instruction_1 = '0;
        instruction_2 = '0;
        next_stalled  = 1'b0;
        #12;
        checkOutput("resetValid", 64'(valid), 64'(0));
        checkOutput("resetStalled", 64'(stalled), 64'(0));
        checkOutput("resetFields", 64'(curOut), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(1'b1, 32'h04432000, 32'h0C22FFFC, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("pairOp1", 64'(curOut), 64'({6'd1, 5'd2, 5'd3, 5'd4, 32'h0, 1'b0}));
        idle(1'b0);
        checkOutput("pairOp2", 64'(curOut), 64'({6'd3, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 1'b0}));
        idle(1'b0);
        checkOutput("pairDone", 64'(valid), 64'(0));

        applyStimulus(1'b1, 32'h00000000, 32'h14A01234, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("nopOp", 64'(curOut), 64'({6'd5, 5'd5, 5'd0, 5'd0, 32'h12340000, 1'b0}));
        idle(1'b0);
        checkOutput("nopSingle", 64'(valid), 64'(0));

        applyStimulus(1'b1, 32'hF8000000, 32'h0, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("illValid", 64'(valid), 64'(1));
        checkOutput("illOp", 64'(curOut), 64'({6'h3E, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1}));
        idle(1'b0);

        applyStimulus(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("doubleNop", 64'(valid), 64'(0));

        // Backpressure: fill while issue is blocked, then drain across wrap.
        startConsumed = consumed;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            if ((DEPTH - modelCount) >= 2) begin
                applyStimulus(1'b1, bpWord(idx, 0), bpWord(idx, 1), 1'b1, 1'b0);
                idx++;
            end else begin
                applyStimulus(1'b1, bpWord(idx, 0), bpWord(idx, 1), 1'b1, 1'b0);
            end
        end
        checkOutput("stallFull", 64'(stalled), 64'(1));
        checkOutput("firstHeld", 64'(curOut), 64'(expDecode(bpWord(0, 0))));
        budget = 0;
        while (idx < 20 && budget < 200) begin
            if ((DEPTH - modelCount) >= 2) begin
                applyStimulus(1'b1, bpWord(idx, 0), bpWord(idx, 1), 1'b0, 1'b0);
                idx++;
            end else begin
                applyStimulus(1'b1, bpWord(idx, 0), bpWord(idx, 1), 1'b0, 1'b0);
            end
            budget++;
        end
        if (idx < 20) checkOutput("acceptTimeout", 64'(idx), 64'(20));
        budget = 0;
        while ((sb.size() != 0) && budget < 50) begin
            idle(1'b0);
            budget++;
        end
        checkOutput("drainEmpty", 64'(sb.size()), 64'(0));
        checkOutput("drainCount", 64'(consumed - startConsumed), 64'(40));
        idle(1'b0);

        // Clear with a full queue, valid output and a fresh pair on the inputs.
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, bpWord(20 + c, 0), bpWord(20 + c, 1), 1'b1, 1'b0);
        end
        checkOutput("preClearValid", 64'(valid), 64'(1));
        applyStimulus(1'b1, 32'h18C60042, 32'h0C00BEEF, 1'b1, 1'b1);
        checkOutput("clearValid", 64'(valid), 64'(0));
        checkOutput("clearStalled", 64'(stalled), 64'(0));
        for (int c = 0; c < 5; c++) idle(1'b0);

        // Asynchronous reset mid-stream, checked before any clock edge.
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, bpWord(30 + c, 0), bpWord(30 + c, 1), 1'b1, 1'b0);
        end
        checkOutput("preResetStalled", 64'(stalled), 64'(1));
        prev_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midResetValid", 64'(valid), 64'(0));
        checkOutput("midResetStalled", 64'(stalled), 64'(0));
        checkOutput("midResetFields", 64'(curOut), 64'(0));
        modelCount = 0;
        modelValid = 1'b0;
        holdPrev   = 1'b0;
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) idle(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/uop_decode.md
# uop_decode

Decode stage that sits directly downstream of the micro-op fetch stage. It accepts up to two 32-bit micro-op words per cycle, buffers them in a small circular queue, and drops all-zero NOP words. It then emits one decoded micro-op per cycle to the issue stage under a valid/stall handshake. It gives the fetch stage its `next_stalled` input and absorbs the 2-in/1-out rate mismatch.

## Interface
Parameters:
- `UOP_WIDTH`, 32: micro-op word width; only 32 is supported.
- `QUEUE_DEPTH`, 4: queue entries; power of two, ≥ 4.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous pipeline flush.
- `prev_valid`  in  1  `instruction_1`/`instruction_2` hold a valid pair.
- `instruction_1`  in  32  older word of the pair.
- `instruction_2`  in  32  younger word of the pair.
- `stalled`  out  1  upstream must hold its pair; drives fetch `next_stalled`.
- `next_stalled`  in  1  downstream cannot accept this cycle.
- `valid`  out  1  decoded outputs are meaningful.
- `opcode`  out  6  `word[31:26]`.
- `rd`  out  5  `word[25:21]`.
- `rs1`  out  5  `word[20:16]`.
- `rs2`  out  5  `word[15:11]` for R-type/STORE, else 0.
- `imm`  out  32  immediate per opcode class.
- `illegal`  out  1  opcode not in the defined set.

## Operation
- **Accept.** A pair is accepted when `prev_valid && !stalled && !clear`.
  - Non-zero words are pushed `instruction_1` first, then `instruction_2`.
  - A word equal to `32'h0` is a NOP and is not pushed. A pair of two NOPs pushes nothing but is still accepted.
- **Stall.** `stalled = (QUEUE_DEPTH - count) < 2`. It is a function of registered `count` only, with no combinational path from `next_stalled`.
- **Pop.** The queue head is popped into the output register when the queue is non-empty, `(!valid || !next_stalled)`, and `!clear`.
  - If `valid && !next_stalled` and the queue is empty, `valid` falls.
  - While `valid && next_stalled`, all outputs hold stable.
- **Simultaneous push/pop.** Allowed in the same cycle. `count` updates by pushes minus pops. Read and write pointers wrap modulo `QUEUE_DEPTH`.
- **Decode rules** (opcode values from the package):
  - `ALU_R` 0x01: `imm` = 0.
  - `ALU_I` 0x02, `LOAD` 0x03, `STORE` 0x04: `imm` = sign-extended `word[15:0]`.
  - `LUI` 0x05: `imm = {word[15:0], 16'h0}`.
  - `BRANCH` 0x06: `imm` = sign-extended `word[15:0]` shifted left by 2.
  - `HALT` 0x3F: `imm` = 0.
  - Any other opcode: `illegal` = 1, fields decoded as for `ALU_R`, and the op is still emitted.
- **Clear.** Next edge: pointers and `count` go to 0 and `valid` goes to 0. The pair presented in the `clear` cycle is discarded.
- **Reset** (asynchronous, `reset` low): pointers, `count`, `valid`, `illegal` and all field outputs go to 0; `stalled` reads 0. Asserting reset mid-stream discards everything in flight.

## Timing
- **Latency.** A word pushed at edge k, into an empty queue with a free output register, is presented on the outputs with `valid` = 1 after edge k+1.
- **Throughput.** 2 words/cycle in, 1 op/cycle out. The queue therefore fills under sustained non-NOP input.
- **Stall threshold.** With `QUEUE_DEPTH` = 4, `stalled` asserts in the cycle after `count` reaches 3.
- **Fetch-side stall.** Upstream sees `stalled` in the same cycle it must hold.

## Structure
- **Package `uop_pkg`:**
  - opcode localparams;
  - field bit positions;
  - a `decoded_uop_t` packed struct (opcode, rd, rs1, rs2, imm, illegal);
  - a pure `decode_uop()` function.
- **Sub-module `uop_queue`:** circular buffer with dual-push/single-pop, pointer wrap and `count`.
- **`uop_decode`:** the push/stall/pop control and the output register.

## Test plan
- **Reset.** Drive `reset` low mid-stream with the queue full → `valid` = 0, `stalled` = 0 and all outputs 0 without a clock edge.
- **Ordered pair.** One pair `0x04432000`, `0x0C22FFFC` → two consecutive valid cycles, in order:
  - op 1: opcode 1, rd 2, rs1 3, rs2 4, imm 0;
  - op 2: opcode 3, rd 1, rs1 2, rs2 0, imm `0xFFFFFFFC`.
- **NOP drop.** Pair (`0x00000000`, `0x14A01234`) → exactly one op: opcode 5, rd 5, imm `0x12340000`.
- **Backpressure and wrap.**
  - Hold `next_stalled` = 1 and offer 20 distinct non-NOP pairs back-to-back → `stalled` asserts once `count` = 3, and the first op holds stable.
  - Release `next_stalled` → all 40 words emerge in order, with no loss or duplicate, across pointer wrap.
- **Clear.** Assert `clear` with the queue full, `valid` = 1, and a new pair presented → next cycle `valid` = 0 and `stalled` = 0, and the presented pair never appears.
- **Illegal opcode.** Word `0xF8000000` → `valid` = 1, `illegal` = 1, opcode `0x3E`, imm 0.
